rr_mux_arb: RTL

- Parametrised successor to the team's 2:1 word multiplexer: NUM_CH-input, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Two modes: round-robin arbitration or forced select, the latter being the legacy sel behaviour.
- Sits between several producer streams and a single consumer.

---
 rtl/rr_mux_arb.sv | 98 +++++++++
 1 files changed

// File: rtl/rr_mux_arb.sv
// NUM_CH-input, WIDTH-bit stream multiplexer with round-robin or forced-select
// arbitration and a single registered output stage (one word per cycle).
module rr_mux_arb #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load;
    logic             xfer;

    assign load = !out_valid_q || out_ready;
    assign xfer = !rst && load && grant_valid;

    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (mode) begin
            // Out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Scan farthest-first so the channel closest to rr_ptr wins last.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (in_valid[idx]) begin
                    grant       = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = load ? 1'b0 : out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant == SEL_W'(i)) out_data_d = in_data[i*WIDTH +: WIDTH];
            end
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            rr_ptr_d    = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule
